// File: rtl/seg_pkg.sv
// Shared definitions for the serial segment driver: pattern geometry and FSM states.
package seg_pkg;

  localparam int SEG_DIGITS = 8;
  localparam int SEG_BITS   = 8;
  localparam int SEG_DATA_W = SEG_DIGITS * SEG_BITS;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT    = 2'd1,
    ST_WAIT_PEN = 2'd2,
    ST_DONE     = 2'd3
  } seg_state_e;

endpackage

// File: rtl/seg_serial_driver_if.sv
// Control-side request/status and board-side serial pins of the segment driver.
interface seg_serial_driver_if
  import seg_pkg::*;
#(
  parameter int DATA_W = SEG_DATA_W
);
  logic              start;
  logic [DATA_W-1:0] seg_txt;
  logic              s_clk;
  logic              s_out;
  logic              s_clrn;
  logic              s_pen;
  logic              busy;
  logic              done;

  modport master (
    output start, seg_txt,
    input  s_clk, s_out, s_clrn, s_pen, busy, done
  );

  modport slave (
    input  start, seg_txt,
    output s_clk, s_out, s_clrn, s_pen, busy, done
  );
endinterface

// File: rtl/seg_sclk_div.sv
// Half-period timer for s_clk: one-cycle phase_tick every HALF_DIV enabled cycles.
module seg_sclk_div #(
  parameter int HALF_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic phase_tick
);
  localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    phase_tick = en && (cnt_q == LAST);
    cnt_d      = cnt_q;
    if (!en || phase_tick) cnt_d = '0;
    else                   cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/seg_serial_driver.sv
// Captures a parallel segment pattern and shifts it MSB first into cascaded
// 74HC164-style registers, then enables the display after a short settle delay.
//
// state       | meaning
// ST_IDLE     | s_clk low, waiting for start; s_pen holds last value
// ST_SHIFT    | clocking bits out, HALF_DIV low then HALF_DIV high per bit
// ST_WAIT_PEN | last bit shifted, s_clk low, counting PEN_DELAY
// ST_DONE     | s_pen raised; schedules the done pulse and drops busy
module seg_serial_driver
  import seg_pkg::*;
#(
  parameter int DATA_W    = SEG_DATA_W,
  parameter int HALF_DIV  = 4,
  parameter int PEN_DELAY = 2
) (
  input logic                clk,
  input logic                rst,
  seg_serial_driver_if.slave bus
);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int PW = (PEN_DELAY > 1) ? $clog2(PEN_DELAY) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  localparam logic [PW-1:0] LAST_PEN = PW'(PEN_DELAY - 1);

  seg_state_e        state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [PW-1:0]     pen_cnt_q, pen_cnt_d;
  logic              s_clk_q, s_clk_d;
  logic              s_clrn_q, s_clrn_d;
  logic              s_pen_q, s_pen_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              div_en;
  logic              phase_tick;

  assign div_en = (state_q == ST_SHIFT);

  seg_sclk_div #(.HALF_DIV(HALF_DIV)) u_sclk_div (
    .clk        (clk),
    .rst        (rst),
    .en         (div_en),
    .phase_tick (phase_tick)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    pen_cnt_d = pen_cnt_q;
    s_clk_d   = s_clk_q;
    s_clrn_d  = 1'b1;
    s_pen_d   = s_pen_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        s_clk_d = 1'b0;
        if (bus.start) begin
          shreg_d   = bus.seg_txt;
          bit_cnt_d = '0;
          pen_cnt_d = '0;
          busy_d    = 1'b1;
          s_pen_d   = 1'b0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (phase_tick) begin
          if (!s_clk_q) begin
            s_clk_d = 1'b1;
          end else begin
            // Data only moves on the falling edge so s_out is stable while s_clk is high.
            s_clk_d = 1'b0;
            if (bit_cnt_q == LAST_BIT) begin
              state_d = ST_WAIT_PEN;
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
              shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
            end
          end
        end
      end
      ST_WAIT_PEN: begin
        if (pen_cnt_q == LAST_PEN) begin
          s_pen_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          pen_cnt_d = pen_cnt_q + PW'(1);
        end
      end
      ST_DONE: begin
        // done/busy are registered, so the pulse lands on the first IDLE cycle.
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      pen_cnt_q <= '0;
      s_clk_q   <= 1'b0;
      s_clrn_q  <= 1'b0;
      s_pen_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      pen_cnt_q <= pen_cnt_d;
      s_clk_q   <= s_clk_d;
      s_clrn_q  <= s_clrn_d;
      s_pen_q   <= s_pen_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.s_clk  = s_clk_q;
  assign bus.s_out  = shreg_q[DATA_W-1];
  assign bus.s_clrn = s_clrn_q;
  assign bus.s_pen  = s_pen_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
endmodule

// File: tb/tb_seg_serial_driver.sv
// Bench for seg_serial_driver: a fast instance (HALF_DIV=1) for the directed cases
// and a default-parameter instance for randomized refreshes.
module tb_seg_serial_driver;
  import seg_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_serial_driver_if #(.DATA_W(64)) bus_a ();
  seg_serial_driver_if #(.DATA_W(64)) bus_b ();

  seg_serial_driver #(.DATA_W(64), .HALF_DIV(1), .PEN_DELAY(2)) u_dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  seg_serial_driver #(.DATA_W(64), .HALF_DIV(4), .PEN_DELAY(2)) u_dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  localparam int LAT_A = 131;
  localparam int LAT_B = 515;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;

  // Observation state per DUT, updated once per cycle at the falling clk edge.
  int          rises[2], done_cnt[2], stab_err[2], last_fall[2], pen_rise[2], done_cyc[2];
  logic [63:0] cap[2];
  logic        prev_clk[2], prev_out[2], prev_pen[2];
  logic        cur_clk[2], cur_out[2], cur_pen[2], cur_clrn[2], cur_busy[2];

  initial begin
    bus_a.start = 1'b0; bus_a.seg_txt = '0;
    bus_b.start = 1'b0; bus_b.seg_txt = '0;
    for (int k = 0; k < 2; k++) begin
      rises[k] = 0; done_cnt[k] = 0; stab_err[k] = 0; last_fall[k] = 0;
      pen_rise[k] = 0; done_cyc[k] = 0; cap[k] = '0;
      prev_clk[k] = 1'b0; prev_out[k] = 1'b0; prev_pen[k] = 1'b0;
    end
  end

  task automatic mon_step(input int k, input logic sclk, input logic sout, input logic spen,
                          input logic dn, input logic bsy, input logic clrn);
    if (sclk === 1'b1 && prev_clk[k] === 1'b0) begin
      rises[k]++;
      cap[k] = {cap[k][62:0], sout};
      if (sout !== prev_out[k]) stab_err[k]++;
    end
    if (sclk === 1'b1 && prev_clk[k] === 1'b1 && sout !== prev_out[k]) stab_err[k]++;
    if (sclk === 1'b0 && prev_clk[k] === 1'b1) last_fall[k] = cyc;
    if (spen === 1'b1 && prev_pen[k] === 1'b0) pen_rise[k] = cyc;
    if (dn === 1'b1) begin
      done_cnt[k]++;
      done_cyc[k] = cyc;
    end
    prev_clk[k] = sclk; prev_out[k] = sout; prev_pen[k] = spen;
    cur_clk[k] = sclk; cur_out[k] = sout; cur_pen[k] = spen;
    cur_clrn[k] = clrn; cur_busy[k] = bsy;
  endtask

  always @(negedge clk) begin
    cyc++;
    mon_step(0, bus_a.s_clk, bus_a.s_out, bus_a.s_pen, bus_a.done, bus_a.busy, bus_a.s_clrn);
    mon_step(1, bus_b.s_clk, bus_b.s_out, bus_b.s_pen, bus_b.done, bus_b.busy, bus_b.s_clrn);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clear_mon();
    for (int k = 0; k < 2; k++) begin
      rises[k] = 0; done_cnt[k] = 0; stab_err[k] = 0; last_fall[k] = 0;
      pen_rise[k] = 0; done_cyc[k] = 0; cap[k] = '0;
    end
  endtask

  task automatic set_in(input int k, input logic st, input logic [63:0] txt);
    if (k == 0) begin bus_a.start = st; bus_a.seg_txt = txt; end
    else        begin bus_b.start = st; bus_b.seg_txt = txt; end
  endtask

  // One refresh: accept, optional mid-refresh start pulse with new data, wait for done.
  task automatic run_refresh(input int k, input logic [63:0] txt, input logic [63:0] exp_cap,
                             input int exp_rises, input int exp_lat, input int exp_gap,
                             input int chg_at, input logic [63:0] chg_txt, input string nm);
    int acc;
    bit got;
    clear_mon();
    set_in(k, 1'b1, txt);
    acc = cyc + 1;
    tick();
    set_in(k, 1'b0, txt);
    chk({nm, "_busy_after_accept"}, 64'(cur_busy[k]), 64'd1);
    chk({nm, "_pen_low_during"}, 64'(cur_pen[k]), 64'd0);
    got = 1'b0;
    for (int t = 0; t < exp_lat + 40 && !got; t++) begin
      if (chg_at >= 0 && t == chg_at) set_in(k, 1'b1, chg_txt);
      else if (chg_at >= 0 && t == chg_at + 1) set_in(k, 1'b0, chg_txt);
      tick();
      if (done_cnt[k] != 0) got = 1'b1;
    end
    chk({nm, "_done_seen"}, 64'(got), 64'd1);
    repeat (8) tick();
    chk({nm, "_rises"}, 64'(rises[k]), 64'(exp_rises));
    chk({nm, "_data"}, cap[k], exp_cap);
    chk({nm, "_done_count"}, 64'(done_cnt[k]), 64'd1);
    chk({nm, "_latency"}, 64'(done_cyc[k] - acc), 64'(exp_lat));
    chk({nm, "_pen_gap"}, 64'(pen_rise[k] - last_fall[k]), 64'(exp_gap));
    chk({nm, "_sout_stable"}, 64'(stab_err[k]), 64'd0);
    chk({nm, "_pen_high_after"}, 64'(cur_pen[k]), 64'd1);
    chk({nm, "_busy_low_after"}, 64'(cur_busy[k]), 64'd0);
    chk({nm, "_sclk_low_after"}, 64'(cur_clk[k]), 64'd0);
  endtask

  typedef struct {
    logic [63:0] txt;
    logic [63:0] exp_cap;
    int          exp_rises;
    int          exp_lat;
    int          exp_gap;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [63:0] p, q;
    bit reached;

    vecs[0] = '{64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 64, LAT_A, 2};
    vecs[1] = '{64'hC0F9_A4B0_9992_82F8, 64'hC0F9_A4B0_9992_82F8, 64, LAT_A, 2};
    vecs[2] = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 64, LAT_A, 2};
    vecs[3] = '{64'h5555_AAAA_0F0F_F0F0, 64'h5555_AAAA_0F0F_F0F0, 64, LAT_A, 2};
    vecs[4] = '{64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 64, LAT_A, 2};

    // Reset and idle
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_clrn_low", 64'(cur_clrn[0]), 64'd0);
    end
    chk("reset_pen", 64'(cur_pen[0]), 64'd0);
    chk("reset_sclk", 64'(cur_clk[0]), 64'd0);
    chk("reset_busy", 64'(cur_busy[0]), 64'd0);
    chk("reset_done", 64'(bus_a.done), 64'd0);
    chk("reset_sout", 64'(cur_out[0]), 64'd0);
    rst = 1'b0;
    tick();
    chk("clrn_release", 64'(cur_clrn[0]), 64'd1);
    chk("idle_pen", 64'(cur_pen[0]), 64'd0);
    chk("idle_busy", 64'(cur_busy[0]), 64'd0);
    clear_mon();
    repeat (100) tick();
    chk("idle_no_edges", 64'(rises[0]), 64'd0);

    // Table-driven refreshes (basic and pattern integrity)
    foreach (vecs[i])
      run_refresh(0, vecs[i].txt, vecs[i].exp_cap, vecs[i].exp_rises, vecs[i].exp_lat,
                  vecs[i].exp_gap, -1, 64'd0, $sformatf("vec%0d", i));

    // Start while busy plus seg_txt change, then the next start captures the new value
    run_refresh(0, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64, LAT_A, 2,
                20, {64{1'b1}}, "busy_start");
    run_refresh(0, {64{1'b1}}, {64{1'b1}}, 64, LAT_A, 2, -1, 64'd0, "after_busy");

    // Reset in the middle of SHIFT
    clear_mon();
    set_in(0, 1'b1, 64'hDEAD_BEEF_0BAD_F00D);
    tick();
    set_in(0, 1'b0, 64'hDEAD_BEEF_0BAD_F00D);
    reached = 1'b0;
    for (int t = 0; t < 200 && !reached; t++) begin
      tick();
      if (rises[0] == 20) reached = 1'b1;
    end
    chk("midrst_reached_20", 64'(reached), 64'd1);
    rst = 1'b1;
    tick();
    chk("midrst_sclk", 64'(cur_clk[0]), 64'd0);
    chk("midrst_pen", 64'(cur_pen[0]), 64'd0);
    chk("midrst_clrn", 64'(cur_clrn[0]), 64'd0);
    chk("midrst_busy", 64'(cur_busy[0]), 64'd0);
    rst = 1'b0;
    repeat (150) tick();
    chk("midrst_no_done", 64'(done_cnt[0]), 64'd0);
    chk("midrst_no_more_edges", 64'(rises[0]), 64'd20);
    run_refresh(0, 64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210, 64, LAT_A, 2,
                -1, 64'd0, "after_midrst");

    // start and rst in the same cycle
    clear_mon();
    rst = 1'b1;
    set_in(0, 1'b1, 64'hFFFF_0000_FFFF_0000);
    tick();
    rst = 1'b0;
    set_in(0, 1'b0, 64'hFFFF_0000_FFFF_0000);
    chk("start_rst_busy", 64'(cur_busy[0]), 64'd0);
    repeat (50) tick();
    chk("start_rst_no_edges", 64'(rises[0]), 64'd0);
    chk("start_rst_busy_later", 64'(cur_busy[0]), 64'd0);
    chk("start_rst_no_done", 64'(done_cnt[0]), 64'd0);

    // Randomized refreshes on the default-parameter instance
    for (int i = 0; i < 3; i++) begin
      p = {$urandom(), $urandom()};
      q = {$urandom(), $urandom()};
      repeat ($urandom_range(0, 5)) tick();
      run_refresh(1, p, p, 64, LAT_B, 2, int'($urandom_range(5, 480)), q,
                  $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/seg_serial_driver.md
Name: seg_serial_driver

Overview:
- Downstream stage of the 8-digit hex-to-segment encoder.
- Captures the 64-bit segment pattern that encoder produces and shifts it serially into the board's cascaded 74HC164-style segment shift registers.
- Generates the serial clock, serial data, register clear and display-enable signals.
- Sits between the segment-pattern generator and the top-level board pins. Refresh is requested with a `start` pulse from the display controller.

Parameters:
- DATA_W, 64, width of the parallel segment pattern (8 digits x 8 segments).
- HALF_DIV, 4, system-clock cycles per half period of s_clk; must be >= 1.
- PEN_DELAY, 2, system-clock cycles between the final s_clk falling edge and s_pen asserting.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle refresh request; sampled only in IDLE.
- seg_txt  input  DATA_W  parallel segment pattern; bits [7:0] are the leftmost digit.
- s_clk  output  1  serial shift clock to the board registers.
- s_out  output  1  serial data; stable whenever s_clk rises.
- s_clrn  output  1  active-low clear to the board registers.
- s_pen  output  1  display output enable; high = pattern shown.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the refresh completes.

Behaviour:
- Reset values (rst high at a clock edge, taking effect that edge):
  - s_clk=0, s_out=0, s_clrn=0, s_pen=0, busy=0, done=0.
  - State is IDLE and all counters are cleared.
  - s_clrn returns to 1 on the first clock after rst deasserts.
- States: IDLE -> SHIFT -> WAIT_PEN -> DONE -> IDLE.
- IDLE:
  - s_clk=0. s_pen keeps its last value: 0 after reset, 1 after any completed refresh.
  - When start=1, the block captures seg_txt into a shift register, sets busy=1, drives s_pen=0 and s_out=seg_txt[DATA_W-1], zeroes the bit counter, and moves to SHIFT.
- SHIFT:
  - Each bit occupies 2*HALF_DIV cycles: HALF_DIV cycles with s_clk=0, then HALF_DIV cycles with s_clk=1.
  - s_out changes only on the cycle s_clk falls, or on entry to SHIFT; it never changes while s_clk=1.
  - Shift order is MSB first: bit DATA_W-1 first, bit 0 last.
  - After the high phase of bit 0, s_clk returns to 0 and the state moves to WAIT_PEN.
- WAIT_PEN:
  - s_clk=0 and s_out holds the last bit, for PEN_DELAY cycles.
  - Then s_pen goes to 1 and the state moves to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Latency, from the start-accept edge to the done pulse: DATA_W*2*HALF_DIV + PEN_DELAY + 1 cycles. With the defaults this is 515.
- Exactly DATA_W rising edges of s_clk occur per refresh.
- start while busy=1 is ignored and not queued. Changes on seg_txt after capture have no effect on the refresh in progress.
- start and rst in the same cycle: reset wins.
- Reset mid-SHIFT: outputs go to their reset values on that edge, s_pen=0. No done pulse is produced.
- Counter widths: the bit counter is clog2(DATA_W) bits, the divider is clog2(HALF_DIV) bits, and neither wraps inside a refresh.

Decomposition:
- Shared package seg_pkg:
  - State encoding localparams: ST_IDLE, ST_SHIFT, ST_WAIT_PEN, ST_DONE.
  - SEG_DIGITS=8 and SEG_BITS=8, with DATA_W derived from them.
- One sub-module, seg_sclk_div:
  - Half-period counter that emits a one-cycle `phase_tick` every HALF_DIV cycles while enabled.
  - Clears synchronously when disabled.
- The FSM consumes phase_tick to toggle s_clk and advance bits.

Test Plan:
1. Reset then idle: hold rst 3 cycles, release. Required:
   - s_clrn=0 during reset and 1 on the next cycle.
   - s_pen=0, s_clk=0, busy=0.
   - No s_clk edges for 100 cycles.
2. Basic refresh: HALF_DIV=1, PEN_DELAY=2, seg_txt=64'h8000_0000_0000_0001, pulse start. Required:
   - 64 s_clk rising edges.
   - s_out=1 at edge 1 and at edge 64, 0 at all others.
   - s_pen rises 2 cycles after the last falling edge.
   - done pulses exactly at 131 cycles after accept.
3. Pattern integrity: seg_txt=64'hC0F9_A4B0_9992_82F8. Required:
   - The bench's 64-bit model register, shifted on each s_clk rise, equals the input after done.
   - s_out is stable for every cycle s_clk=1.
4. Busy-start and input change: pulse start again and change seg_txt to all ones mid-SHIFT. Required:
   - Still exactly 64 edges, with the original data.
   - Exactly one done pulse.
   - The next start after done captures all ones.
5. Reset mid-shift: assert rst after 20 bits. Required:
   - On that edge: s_clk=0, s_pen=0, s_clrn=0, busy=0.
   - No done pulse.
   - A subsequent start performs a complete 64-bit refresh.
6. Simultaneous start+rst: reset wins. busy stays 0 and no s_clk edges occur.
